// File: rtl/d2c_pt_sb_arbiter.sv
// Sideband transmit arbiter for the point-test responders.
// The TX-initiated and RX-initiated responders share one SB encoder. This block
// grants one side at a time, holds the granted code until the encoder finishes,
// returns the done pulse to the owner only, and watches for hung transfers.
module d2c_pt_sb_arbiter #(
  parameter int unsigned SB_MSG_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid_tx,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_msg_tx,
  input  logic                    i_valid_rx,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_msg_rx,
  input  logic                    i_SB_Busy,
  input  logic                    i_timeout_clr,
  output logic                    o_SB_msg_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_msg_source,
  output logic                    o_falling_edge_busy_tx,
  output logic                    o_falling_edge_busy_rx,
  output logic                    o_tx_valid_to_rx,
  output logic                    o_rx_valid_to_tx,
  output logic                    o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen on the edge that completes the last allowed cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusyFall,
    StRelease
  } state_e;

  state_e          state_q;
  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic            last_grant_q;  // 0 TX, 1 RX

  logic busy_fall;
  logic owner_valid;
  logic grant_rx;
  logic expire;

  // Arbitration and event decode from current inputs and state.
  always_comb begin
    busy_fall   = busy_q & ~i_SB_Busy;
    owner_valid = o_msg_source ? i_valid_rx : i_valid_tx;
    // RX wins when alone, or on a tie when TX had the previous grant.
    grant_rx    = i_valid_rx & (~i_valid_tx | ~last_grant_q);
    expire      = (cnt_q == CntLast);
  end

  // Peer indications: the other side's request or its in-flight ownership.
  always_comb begin
    o_tx_valid_to_rx = i_valid_tx | ((state_q != StIdle) & ~o_msg_source);
    o_rx_valid_to_tx = i_valid_rx | ((state_q != StIdle) & o_msg_source);
  end

  // Grant FSM with registered outputs, busy edge detect and watchdog.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q                <= StIdle;
      busy_q                 <= 1'b0;
      cnt_q                  <= '0;
      last_grant_q           <= 1'b1;
      o_SB_msg_valid         <= 1'b0;
      o_encoded_SB_msg       <= '0;
      o_msg_source           <= 1'b0;
      o_falling_edge_busy_tx <= 1'b0;
      o_falling_edge_busy_rx <= 1'b0;
      o_timeout              <= 1'b0;
    end else begin
      busy_q                 <= i_SB_Busy;
      o_falling_edge_busy_tx <= 1'b0;
      o_falling_edge_busy_rx <= 1'b0;
      // A later set in this block overrides the clear.
      if (i_timeout_clr) o_timeout <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (i_valid_tx | i_valid_rx) begin
            state_q          <= StIssue;
            o_SB_msg_valid   <= 1'b1;
            o_msg_source     <= grant_rx;
            last_grant_q     <= grant_rx;
            o_encoded_SB_msg <= grant_rx ? i_encoded_msg_rx : i_encoded_msg_tx;
            cnt_q            <= '0;
          end
        end
        StIssue: begin
          cnt_q <= cnt_q + CntW'(1);
          if (expire) begin
            o_timeout      <= 1'b1;
            o_SB_msg_valid <= 1'b0;
            state_q        <= StIdle;
          end else if (i_SB_Busy) begin
            state_q <= StWaitBusyFall;
          end else if (!owner_valid) begin
            o_SB_msg_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
        StWaitBusyFall: begin
          cnt_q <= cnt_q + CntW'(1);
          // Completion beats a coincident watchdog expiry.
          if (busy_fall) begin
            o_SB_msg_valid <= 1'b0;
            if (o_msg_source) o_falling_edge_busy_rx <= 1'b1;
            else              o_falling_edge_busy_tx <= 1'b1;
            state_q <= StRelease;
          end else if (expire) begin
            o_timeout      <= 1'b1;
            o_SB_msg_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
        StRelease: begin
          if (!owner_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_d2c_pt_sb_arbiter.sv
// Self-checking bench for d2c_pt_sb_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_d2c_pt_sb_arbiter;

  localparam int W = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vtx = 1'b0, vrx = 1'b0, busy = 1'b0, tclr = 1'b0;
  logic [W-1:0] mtx = '0, mrx = '0;

  logic         sb_valid, src, ptx, prx, tx2rx, rx2tx, tout;
  logic [W-1:0] sb_msg;

  always #5 clk = ~clk;

  d2c_pt_sb_arbiter #(
    .SB_MSG_WIDTH  (W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_valid_tx            (vtx),
    .i_encoded_msg_tx      (mtx),
    .i_valid_rx            (vrx),
    .i_encoded_msg_rx      (mrx),
    .i_SB_Busy             (busy),
    .i_timeout_clr         (tclr),
    .o_SB_msg_valid        (sb_valid),
    .o_encoded_SB_msg      (sb_msg),
    .o_msg_source          (src),
    .o_falling_edge_busy_tx(ptx),
    .o_falling_edge_busy_rx(prx),
    .o_tx_valid_to_rx      (tx2rx),
    .o_rx_valid_to_tx      (rx2tx),
    .o_timeout             (tout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_ptx  = 0;
  int cnt_prx  = 0;

  // Reference model: who owns the encoder and which phase of a transfer it is in.
  // phase 0: free, 1: offered (waiting for busy), 2: encoder busy, 3: done, owner still asserting
  int           m_phase;
  bit           m_owner, m_prev_owner, m_valid, m_to, m_ptx, m_prx, m_busy_prev;
  logic [W-1:0] m_msg;
  int           m_age;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_prev_owner = 1; m_valid = 0; m_to = 0;
    m_ptx = 0; m_prx = 0; m_busy_prev = 0; m_msg = '0; m_age = 0;
  endfunction

  function automatic void model_edge();
    bit fall, own_req;
    fall    = m_busy_prev && !busy;
    own_req = m_owner ? vrx : vtx;
    m_ptx   = 0;
    m_prx   = 0;
    if (tclr) m_to = 0;
    case (m_phase)
      0: if (vtx || vrx) begin
        m_owner      = (vtx && vrx) ? !m_prev_owner : vrx;
        m_prev_owner = m_owner;
        m_msg        = m_owner ? mrx : mtx;
        m_valid      = 1;
        m_age        = 0;
        m_phase      = 1;
      end
      1: begin
        m_age++;
        if (m_age == T) begin m_to = 1; m_valid = 0; m_phase = 0; end
        else if (busy) m_phase = 2;
        else if (!own_req) begin m_valid = 0; m_phase = 0; end
      end
      2: begin
        m_age++;
        if (fall) begin
          m_valid = 0;
          if (m_owner) m_prx = 1; else m_ptx = 1;
          m_phase = 3;
        end else if (m_age == T) begin
          m_to = 1; m_valid = 0; m_phase = 0;
        end
      end
      default: if (!own_req) m_phase = 0;
    endcase
    m_busy_prev = busy;
  endfunction

  task automatic check_outputs();
    check_eq("sb_valid", 32'(sb_valid), 32'(m_valid));
    check_eq("sb_msg",   32'(sb_msg),   32'(m_msg));
    check_eq("source",   32'(src),      32'(m_owner));
    check_eq("pulse_tx", 32'(ptx),      32'(m_ptx));
    check_eq("pulse_rx", 32'(prx),      32'(m_prx));
    check_eq("timeout",  32'(tout),     32'(m_to));
    check_eq("tx2rx",    32'(tx2rx),    32'(vtx | (m_phase != 0 && m_owner == 0)));
    check_eq("rx2tx",    32'(rx2tx),    32'(vrx | (m_phase != 0 && m_owner == 1)));
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_outputs();
      cnt_ptx += int'(ptx);
      cnt_prx += int'(prx);
    end
  endtask

  task automatic idle_inputs();
    vtx = 0; vrx = 0; busy = 0; tclr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1 check_outputs();
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    step(2);  // outputs held at reset values
    rst_n = 1;
    step(1);

    // TX only: busy rises 2 cycles after grant, falls 6 cycles after grant
    cnt_ptx = 0; cnt_prx = 0;
    vtx = 1; mtx = 4'd5;
    step(1);
    check_eq("txonly_valid", 32'(sb_valid), 32'd1);
    check_eq("txonly_code", 32'(sb_msg), 32'd5);
    mtx = 4'd11;  // ignored after grant
    step(1);
    busy = 1; step(4);
    busy = 0; step(1);
    check_eq("txonly_pulse_now", 32'(ptx), 32'd1);
    step(2);
    vtx = 0; step(2);
    check_eq("txonly_ptx_count", 32'(cnt_ptx), 32'd1);
    check_eq("txonly_prx_count", 32'(cnt_prx), 32'd0);

    // Tie after reset: TX first, then RX, then a fresh tie goes to RX
    do_reset();
    vtx = 1; mtx = 4'd1; vrx = 1; mrx = 4'd2;
    step(1);
    check_eq("tie1_code", 32'(sb_msg), 32'd1);
    busy = 1; step(2);
    busy = 0; step(1);
    vtx = 0; step(1);  // release -> idle
    vtx = 1;           // tie again on the next edge
    step(1);
    check_eq("tie2_code", 32'(sb_msg), 32'd2);
    check_eq("tie2_source", 32'(src), 32'd1);
    busy = 1; step(2);
    busy = 0; step(1);
    vrx = 0; vtx = 0; step(2);

    // RX request while TX owns the encoder
    do_reset();
    vtx = 1; mtx = 4'd3;
    step(1);
    busy = 1; step(1);
    vrx = 1; mrx = 4'd9;
    step(1);
    check_eq("peer_tx2rx", 32'(tx2rx), 32'd1);
    check_eq("peer_owner", 32'(src), 32'd0);
    busy = 0; step(3);
    check_eq("peer_hold_source", 32'(src), 32'd0);
    vtx = 0; step(1);
    check_eq("peer_gap", 32'(sb_valid), 32'd0);
    step(1);
    check_eq("peer_rx_code", 32'(sb_msg), 32'd9);
    check_eq("peer_rx_source", 32'(src), 32'd1);
    busy = 1; step(2);
    busy = 0; step(1);
    vrx = 0; step(2);

    // Withdraw before busy rises
    cnt_ptx = 0; cnt_prx = 0;
    vtx = 1; mtx = 4'd6; step(1);
    vtx = 0; step(1);
    check_eq("withdraw_valid", 32'(sb_valid), 32'd0);
    step(2);
    check_eq("withdraw_pulses", 32'(cnt_ptx + cnt_prx), 32'd0);

    // Watchdog expiry with busy stuck low, retry, and clear
    vtx = 1; mtx = 4'd7; step(1);
    step(T);
    check_eq("wd_flag", 32'(tout), 32'd1);
    check_eq("wd_valid_drop", 32'(sb_valid), 32'd0);
    step(1);
    check_eq("wd_regrant", 32'(sb_valid), 32'd1);
    tclr = 1; step(1);
    check_eq("wd_clear", 32'(tout), 32'd0);
    tclr = 0; vtx = 0; step(2);

    // Busy falls on the expiry cycle: completion wins
    cnt_ptx = 0;
    vtx = 1; mtx = 4'd4; step(1);
    busy = 1; step(T - 1);
    busy = 0; step(1);
    check_eq("wd_race_pulse", 32'(ptx), 32'd1);
    check_eq("wd_race_flag", 32'(tout), 32'd0);
    vtx = 0; step(2);

    // Asynchronous reset during an active transfer
    vtx = 1; mtx = 4'd5; step(1);
    busy = 1; step(2);
    #2 rst_n = 0;
    #1;
    check_eq("arst_valid", 32'(sb_valid), 32'd0);
    check_eq("arst_msg", 32'(sb_msg), 32'd0);
    check_eq("arst_pulse", 32'(ptx | prx), 32'd0);
    check_eq("arst_timeout", 32'(tout), 32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    cnt_ptx = 0; cnt_prx = 0;
    step(2);
    check_eq("arst_no_pulse", 32'(cnt_ptx + cnt_prx), 32'd0);
    vtx = 1; vrx = 1; mtx = 4'd12; mrx = 4'd13;
    step(1);
    check_eq("arst_tie_source", 32'(src), 32'd0);
    idle_inputs();
    step(3);

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) vtx = ~vtx;
      if ($urandom_range(5) == 0) vrx = ~vrx;
      if ($urandom_range(3) == 0) busy = ~busy;
      tclr = ($urandom_range(15) == 0);
      mtx  = W'($urandom);
      mrx  = W'($urandom);
      step(1);
    end
    idle_inputs();
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
